mem_rr_arb: RTL and testbench
=============================

# mem_rr_arb

N-port round-robin arbiter sharing the single native memory bus (valid/ready, 32-bit addr/data, 4-bit wstrb) between several bus masters, e.g. CPU instruction fetch, CPU data port, DMA and debug. It sits between the masters and the memory/peripheral interconnect. It grants one master per transaction with rotating priority, chains grants back-to-back, and aborts transactions the slave never acknowledges via a timeout watchdog.

## Interface
- N, default 4: number of master ports, 2..8.
- TIMEOUT, default 255: cycles a granted transaction may wait for mem_ready before abort; 0 disables the watchdog.
- ERR_DATA, default 32'hDEADBEEF: read data returned on a timed-out transaction.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- m_valid  in  N  per-master request.
- m_ready  out  N  per-master completion pulse.
- m_addr  in  32*N  per-master address; port i at bits [32i+31:32i].
- m_wdata  in  32*N  per-master write data.
- m_wstrb  in  4*N  per-master byte strobes; 0 means read.
- m_rdata  out  32  shared read data to all masters.
- mem_valid  out  1  master-side request.
- mem_ready  in  1  slave completion.
- mem_addr  out  32  muxed address.
- mem_wdata  out  32  muxed write data.
- mem_wstrb  out  4  muxed strobes; forced 0 when mem_valid=0.
- mem_rdata  in  32  slave read data.
- bus_err  out  1  one-cycle pulse on timeout abort.
- err_port  out  3  index of the last timed-out master; holds its value until the next abort.
- err_count  out  8  saturating count of timeout aborts.

## Operation
- Registers: state (IDLE, BUSY), gnt index, ptr (round-robin start), wait counter, err_port, err_count.
- Round-robin select: the first i with m_valid[i]=1, searching from ptr upward and wrapping modulo N.
- IDLE: if any m_valid is set, gnt <= select, state <= BUSY, wait counter <= 0.
- BUSY: mem_valid=1. mem_addr, mem_wdata and mem_wstrb come from port gnt.
  - On mem_ready=1: m_ready[gnt]=1 combinationally in the same cycle. m_rdata=mem_rdata. ptr <= (gnt+1) mod N.
  - The next grant is chosen in that same cycle from m_valid with bit gnt masked off, searching from (gnt+1) mod N. If a master is found, stay BUSY with the new gnt and clear the wait counter. If none, go to IDLE.
  - On no mem_ready: the wait counter increments.
  - If TIMEOUT!=0 and the counter equals TIMEOUT-1 while mem_ready=0: m_ready[gnt]=1, m_rdata=ERR_DATA, bus_err=1, err_port <= gnt, err_count <= min(err_count+1, 255). ptr advances as on normal completion; the state goes to IDLE with no chaining.
- m_rdata equals mem_rdata at all times except in the abort cycle.
- Masters must hold valid, addr, wdata and wstrb stable until their m_ready. Dropping m_valid while granted is ignored: the transaction continues to completion.
- mem_ready arriving in IDLE, including a late response after an abort, is ignored; no m_ready is generated.
- The masked-gnt rule prevents a master that re-requests immediately from starving the others.
- At most one bit of m_ready is set in any cycle.

## Timing
- Reset values: state=IDLE, gnt=0, ptr=0, counter=0, mem_valid=0, mem_wstrb=0, m_ready=0, bus_err=0, err_port=0, err_count=0. mem_addr and mem_wdata follow port 0.
- rst asserted mid-transaction: mem_valid=0 in the following cycle. No m_ready is issued for the aborted transaction.
- Latency from idle: m_valid rises in cycle t, mem_valid is high in cycle t+1. With a zero-wait slave, m_ready fires in t+1.
- Back-to-back chaining: the completion cycle of one grant and the mem_valid of the next grant are in consecutive cycles, with no idle gap.
- Timeout: with mem_valid first high in cycle s, the abort pulse occurs in cycle s+TIMEOUT-1. mem_ready=1 in that same cycle wins: normal completion, no error.
- Simultaneous requests from IDLE are resolved by ptr. After reset, port 0 has top priority.

## Test plan
- Single master, zero-wait slave: m_valid[2]=1 with addr 0x100 at cycle 1 -> mem_valid and mem_addr=0x100 at cycle 2, m_ready[2]=1 at cycle 2; m_ready[2]=0 and mem_valid=0 at cycle 3.
- All four masters requesting continuously after reset: grant order 0,1,2,3,0 with no idle cycle between grants; no master waits more than 3 transactions.
- Write passthrough: port 1 with wstrb=4'b0011 and wdata=0xA5A5A5A5 -> mem_wstrb=0011 and mem_wdata=0xA5A5A5A5 while granted; mem_wstrb=0 when idle.
- Timeout with TIMEOUT=8 and mem_ready held 0: m_ready[gnt] and bus_err pulse 7 cycles after mem_valid rises, with m_rdata=0xDEADBEEF; err_port=gnt, err_count=1. A late mem_ready in IDLE produces no m_ready.
- Boundary: mem_ready in exactly the timeout cycle -> normal completion, bus_err=0. Repeat for 300 aborts -> err_count saturates at 255.
- Reset during BUSY with a waiting slave: mem_valid=0 and m_ready=0 in the next cycle; ptr=0 again, so port 0 wins the next simultaneous request.

Source files
------------

// File: rtl/mem_rr_arb_if.sv
// Signal bundle between the bus masters, the round-robin arbiter and the shared memory bus.
interface mem_rr_arb_if #(
    parameter int unsigned N = 4
);
    logic [N-1:0]    m_valid;
    logic [N-1:0]    m_ready;
    logic [32*N-1:0] m_addr;
    logic [32*N-1:0] m_wdata;
    logic [4*N-1:0]  m_wstrb;
    logic [31:0]     m_rdata;
    logic            mem_valid;
    logic            mem_ready;
    logic [31:0]     mem_addr;
    logic [31:0]     mem_wdata;
    logic [3:0]      mem_wstrb;
    logic [31:0]     mem_rdata;
    logic            bus_err;
    logic [2:0]      err_port;
    logic [7:0]      err_count;

    // Arbiter view
    modport slave (
        input  m_valid, m_addr, m_wdata, m_wstrb, mem_ready, mem_rdata,
        output m_ready, m_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output bus_err, err_port, err_count
    );

    // Environment view: masters plus the memory slave
    modport master (
        output m_valid, m_addr, m_wdata, m_wstrb, mem_ready, mem_rdata,
        input  m_ready, m_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  bus_err, err_port, err_count
    );
endinterface

// File: rtl/mem_rr_arb.sv
// N-port round-robin arbiter for the native memory bus, with back-to-back grant
// chaining and a watchdog that aborts transactions the slave never acknowledges.
module mem_rr_arb #(
    parameter int unsigned N        = 4,
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    mem_rr_arb_if.slave bus
);
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  gnt_q, gnt_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     err_port_q, err_port_d;
    logic [7:0]     err_count_q, err_count_d;

    logic [IW-1:0]  gnt_inc;
    logic [N-1:0]   chain_req;
    logic           timeout_hit;
    logic [3:0]     sel_wstrb;

    // First requester at or after start, wrapping modulo N
    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] req, input logic [IW-1:0] start);
        logic [IW-1:0] idx;
        rr_pick = start;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            idx = IW'((32'(start) + 32'(k)) % N);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            err_port_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            err_port_q  <= err_port_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        err_port_d  = err_port_q;
        err_count_d = err_count_q;
        bus.m_ready = '0;
        bus.m_rdata = bus.mem_rdata;
        bus.bus_err = 1'b0;
        bus.mem_valid = 1'b0;

        gnt_inc     = IW'((32'(gnt_q) + 32'd1) % N);
        // The finishing master is masked so an immediate re-request cannot starve the others
        chain_req   = bus.m_valid;
        chain_req[gnt_q] = 1'b0;
        timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

        case (state_q)
            IDLE: begin
                if (|bus.m_valid) begin
                    gnt_d   = rr_pick(bus.m_valid, ptr_q);
                    state_d = BUSY;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                bus.mem_valid = 1'b1;
                if (bus.mem_ready) begin
                    bus.m_ready[gnt_q] = 1'b1;
                    ptr_d = gnt_inc;
                    if (|chain_req) begin
                        gnt_d = rr_pick(chain_req, gnt_inc);
                        cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (timeout_hit) begin
                    bus.m_ready[gnt_q] = 1'b1;
                    bus.m_rdata = ERR_DATA;
                    bus.bus_err = 1'b1;
                    err_port_d  = 3'(gnt_q);
                    if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
                    ptr_d   = gnt_inc;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request payload mux from the granted port; strobes only qualified while a grant is live
    always_comb begin
        bus.mem_addr  = bus.m_addr[31:0];
        bus.mem_wdata = bus.m_wdata[31:0];
        sel_wstrb     = bus.m_wstrb[3:0];
        for (int i = 0; i < int'(N); i++) begin
            if (gnt_q == IW'(i)) begin
                bus.mem_addr  = bus.m_addr[32*i +: 32];
                bus.mem_wdata = bus.m_wdata[32*i +: 32];
                sel_wstrb     = bus.m_wstrb[4*i +: 4];
            end
        end
        bus.mem_wstrb = (state_q == BUSY) ? sel_wstrb : 4'h0;
    end

    assign bus.err_port  = err_port_q;
    assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_mem_rr_arb.sv
// Scoreboard bench for mem_rr_arb: masters push expected transactions, a negedge
// monitor predicts arbitration from the round-robin rules and checks every cycle.
module tb_mem_rr_arb;
    localparam int unsigned N        = 4;
    localparam int unsigned TIMEOUT  = 8;
    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_rr_arb_if #(.N(N)) bus ();

    mem_rr_arb #(.N(N), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    txn_t       exp_q [N][$];
    int         grant_port [$];
    int         grant_cyc  [$];
    logic [N-1:0] act     = '0;
    logic [N-1:0] mr_seen = '0;
    bit         rand_en = 1'b0;
    int         rate    = 0;
    int         mode    = 0;   // slave: 0 zero-wait, 1 random, 2 never, 3 exactly at the watchdog limit

    // Reference state: who owns the bus and for how long, round-robin start, error history
    bit m_busy  = 1'b0;
    int m_port  = 0;
    int m_wait  = 0;
    int m_ptr   = 0;
    int m_errs  = 0;
    int m_eport = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] req, input int start);
        for (int k = 0; k < int'(N); k++)
            if (req[(start + k) % int'(N)]) return (start + k) % int'(N);
        return 0;
    endfunction

    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
        txn_t t;
        t.addr = a; t.wdata = w; t.wstrb = s;
        bus.m_addr[32*i +: 32]  = a;
        bus.m_wdata[32*i +: 32] = w;
        bus.m_wstrb[4*i +: 4]   = s;
        bus.m_valid[i] = 1'b1;
        act[i] = 1'b1;
        exp_q[i].push_back(t);
    endtask

    // Advance to just after the next rising edge and drive masters and slave for that cycle
    task automatic cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(N); i++) begin
            if (mr_seen[i]) begin
                act[i] = 1'b0;
                bus.m_valid[i] = 1'b0;
            end
            if (!act[i] && rand_en && int'($urandom_range(0, 99)) < rate)
                issue(i, {4'(i), 28'($urandom())}, $urandom(),
                      ($urandom_range(0, 1) == 1) ? 4'($urandom()) : 4'h0);
        end
        case (mode)
            0:       bus.mem_ready = 1'b1;
            1:       bus.mem_ready = ($urandom_range(0, 2) == 0);
            3:       bus.mem_ready = m_busy && (m_wait == int'(TIMEOUT) - 1);
            default: bus.mem_ready = 1'b0;
        endcase
        bus.mem_rdata = $urandom();
    endtask

    task automatic drain();
        int k;
        rand_en = 1'b0;
        k = 0;
        while (act != '0 && k < 200) begin
            cycle();
            k++;
        end
        chk("drain_outstanding", 32'(act), 32'd0);
    endtask

    task automatic do_reset();
        rand_en = 1'b0;
        cycle();
        rst = 1'b1;
        bus.m_valid = '0;
        act = '0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    // Monitor: compare the DUT against the reference, then advance the reference by one cycle
    always @(negedge clk) begin : mon
        txn_t t;
        bit done, abrt;
        logic [N-1:0] cand;
        logic [N-1:0] exp_mr;
        cyc++;
        mr_seen = bus.m_ready;
        if (rst) begin
            m_busy = 1'b0; m_port = 0; m_wait = 0; m_ptr = 0; m_errs = 0; m_eport = 0;
            for (int i = 0; i < int'(N); i++) exp_q[i].delete();
        end else begin
            chk("err_count", 32'(bus.err_count), 32'(m_errs));
            chk("err_port", 32'(bus.err_port), 32'(m_eport));
            chk("mem_valid", 32'(bus.mem_valid), 32'(m_busy));
            done = m_busy && bus.mem_ready;
            abrt = m_busy && !bus.mem_ready && (m_wait == int'(TIMEOUT) - 1);
            if (m_busy) begin
                chk("txn_outstanding", 32'(exp_q[m_port].size()), 32'd1);
                if (exp_q[m_port].size() > 0) begin
                    t = exp_q[m_port][0];
                    chk("mem_addr", bus.mem_addr, t.addr);
                    chk("mem_wdata", bus.mem_wdata, t.wdata);
                    chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(t.wstrb));
                end
            end else begin
                chk("mem_wstrb_idle", 32'(bus.mem_wstrb), 32'd0);
            end
            exp_mr = '0;
            if (done || abrt) exp_mr[m_port] = 1'b1;
            chk("m_ready", 32'(bus.m_ready), 32'(exp_mr));
            chk("bus_err", 32'(bus.bus_err), 32'(abrt));
            chk("m_rdata", bus.m_rdata, abrt ? ERR_DATA : bus.mem_rdata);
            for (int i = 0; i < int'(N); i++)
                if (bus.m_ready[i]) begin
                    grant_port.push_back(i);
                    grant_cyc.push_back(cyc);
                end
            if (done || abrt) begin
                if (exp_q[m_port].size() > 0) void'(exp_q[m_port].pop_front());
                m_ptr = (m_port + 1) % int'(N);
                if (abrt) begin
                    m_errs  = (m_errs < 255) ? m_errs + 1 : 255;
                    m_eport = m_port;
                    m_busy  = 1'b0;
                end else begin
                    cand = bus.m_valid;
                    cand[m_port] = 1'b0;
                    if (cand != '0) begin
                        m_port = rr_pick(cand, m_ptr);
                        m_wait = 0;
                    end else begin
                        m_busy = 1'b0;
                    end
                end
            end else if (m_busy) begin
                m_wait++;
            end else if (bus.m_valid != '0) begin
                m_port = rr_pick(bus.m_valid, m_ptr);
                m_busy = 1'b1;
                m_wait = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles, expected far fewer", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s, e;
        rst = 1'b1;
        bus.m_valid   = '0;
        bus.m_addr    = '0;
        bus.m_wdata   = '0;
        bus.m_wstrb   = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        bus.m_addr[31:0] = 32'h0000_1234;

        // Reset values
        do_reset();
        @(negedge clk);
        chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("rst_m_ready", 32'(bus.m_ready), 32'd0);
        chk("rst_bus_err", 32'(bus.bus_err), 32'd0);
        chk("rst_err_port", 32'(bus.err_port), 32'd0);
        chk("rst_err_count", 32'(bus.err_count), 32'd0);
        chk("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0000_1234);

        // Single master, zero-wait slave
        mode = 0;
        cycle();
        issue(2, 32'h0000_0100, 32'h0, 4'h0);
        @(negedge clk);
        chk("single_idle", 32'(bus.mem_valid), 32'd0);
        cycle();
        @(negedge clk);
        chk("single_mem_valid", 32'(bus.mem_valid), 32'd1);
        chk("single_mem_addr", bus.mem_addr, 32'h0000_0100);
        chk("single_m_ready", 32'(bus.m_ready), 32'h4);
        cycle();
        @(negedge clk);
        chk("single_done_ready", 32'(bus.m_ready), 32'd0);
        chk("single_done_valid", 32'(bus.mem_valid), 32'd0);

        // All four masters requesting continuously after reset
        do_reset();
        grant_port.delete();
        grant_cyc.delete();
        cycle();
        for (int i = 0; i < int'(N); i++) issue(i, {4'(i), 28'($urandom())}, $urandom(), 4'h0);
        rate = 100;
        rand_en = 1'b1;
        repeat (8) cycle();
        drain();
        chk("rr_grant_count", 32'(grant_port.size() >= 8), 32'd1);
        if (grant_port.size() >= 8)
            for (int k = 0; k < 8; k++) begin
                chk("rr_order", 32'(grant_port[k]), 32'(k % 4));
                chk("rr_no_gap", 32'(grant_cyc[k]), 32'(grant_cyc[0] + k));
            end

        // Write passthrough
        cycle();
        issue(1, 32'h1000_0040, 32'hA5A5_A5A5, 4'b0011);
        cycle();
        @(negedge clk);
        chk("wr_mem_wstrb", 32'(bus.mem_wstrb), 32'h3);
        chk("wr_mem_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
        cycle();
        @(negedge clk);
        chk("wr_idle_wstrb", 32'(bus.mem_wstrb), 32'd0);

        // Watchdog abort with a silent slave
        mode = 2;
        cycle();
        issue(3, 32'h3000_0010, 32'h0, 4'h0);
        s = -1;
        e = -1;
        for (int k = 0; k < 20 && e < 0; k++) begin
            @(negedge clk);
            if (bus.mem_valid && s < 0) s = k;
            if (bus.bus_err) begin
                e = k;
                chk("to_m_ready", 32'(bus.m_ready), 32'h8);
                chk("to_m_rdata", bus.m_rdata, 32'hDEADBEEF);
            end
            cycle();
        end
        chk("to_latency", 32'(e - s), 32'd7);
        @(negedge clk);
        chk("to_err_port", 32'(bus.err_port), 32'd3);
        chk("to_err_count", 32'(bus.err_count), 32'd1);
        mode = 0;
        repeat (2) begin
            cycle();
            @(negedge clk);
            chk("late_ready_ignored", 32'(bus.m_ready), 32'd0);
        end

        // Slave answers in exactly the watchdog cycle: normal completion
        mode = 3;
        cycle();
        issue(0, 32'h0000_0080, 32'h0, 4'h0);
        s = -1;
        e = -1;
        for (int k = 0; k < 20 && e < 0; k++) begin
            @(negedge clk);
            if (bus.mem_valid && s < 0) s = k;
            if (bus.m_ready != '0) begin
                e = k;
                chk("edge_bus_err", 32'(bus.bus_err), 32'd0);
                chk("edge_m_ready", 32'(bus.m_ready), 32'h1);
            end
            cycle();
        end
        chk("edge_latency", 32'(e - s), 32'd7);
        @(negedge clk);
        chk("edge_err_count", 32'(bus.err_count), 32'd1);

        // Random traffic against a random-latency slave
        mode = 1;
        rate = 30;
        rand_en = 1'b1;
        repeat (3000) cycle();
        drain();

        // Continuous aborts until the error counter saturates
        mode = 2;
        rate = 100;
        rand_en = 1'b1;
        repeat (2800) cycle();
        drain();
        @(negedge clk);
        chk("err_count_sat", 32'(bus.err_count), 32'd255);

        // Reset while a transaction waits on the slave
        do_reset();
        mode = 0;
        cycle();
        issue(1, 32'h1000_0000, 32'h0, 4'h0);
        repeat (3) cycle();
        mode = 2;
        issue(2, 32'h2000_0000, 32'h0, 4'h0);
        repeat (3) cycle();
        rst = 1'b1;
        bus.m_valid = '0;
        act = '0;
        @(negedge clk);
        cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("midrst_m_ready", 32'(bus.m_ready), 32'd0);
        grant_port.delete();
        grant_cyc.delete();
        mode = 0;
        cycle();
        for (int i = 0; i < int'(N); i++) issue(i, {4'(i), 28'($urandom())}, $urandom(), 4'h0);
        repeat (3) cycle();
        chk("midrst_winner", (grant_port.size() > 0) ? 32'(grant_port[0]) : 32'hFFFF_FFFF, 32'd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
